// File: rtl/noise_injector.sv
// noise_injector: adds attenuated Galois-LFSR noise to signed samples,
// saturates the sum and presents it through a 2-entry valid/ready buffer.
module noise_injector #(
  parameter int                 DATA_W    = 24,
  parameter logic [DATA_W-1:0]  LFSR_TAPS = 24'hE10000,
  parameter logic [DATA_W-1:0]  LFSR_SEED = 24'hACE15B,
  parameter int                 SAT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              noise_en,
  input  logic [4:0]        noise_shift,
  input  logic              seed_load,
  input  logic [DATA_W-1:0] seed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SAT_W-1:0]  sat_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  localparam logic [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [SAT_W-1:0]  SAT_MAX = {SAT_W{1'b1}};

  // One Galois step: shift right, fold taps back in when the bit shifted out is 1.
  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] cur);
    logic [DATA_W-1:0] nxt;
    if (cur[0]) begin
      nxt = (cur >> 1) ^ LFSR_TAPS;
    end else begin
      nxt = cur >> 1;
    end
    return nxt;
  endfunction

  buf_state_t          state_r;
  logic [DATA_W-1:0]   tail_r;
  logic [DATA_W-1:0]   lfsr_r;

  logic                accept_s;
  logic                pop_s;
  logic signed [DATA_W-1:0] noise_s;
  logic [DATA_W:0]     sum_s;
  logic [DATA_W-1:0]   result_s;
  logic                sat_s;

  assign accept_s = in_valid & in_ready;
  assign pop_s    = out_valid & out_ready;

  // Noise from the current (pre-update) LFSR value, attenuated by noise_shift.
  always_comb begin
    noise_s = '0;
    if (noise_en && (int'(noise_shift) < DATA_W)) begin
      noise_s = $signed(lfsr_r) >>> noise_shift;
    end else begin
      noise_s = '0;
    end
  end

  // Widen by one bit, add, and clamp to the signed DATA_W range.
  always_comb begin
    sum_s    = {in_data[DATA_W-1], in_data} + {noise_s[DATA_W-1], noise_s};
    result_s = sum_s[DATA_W-1:0];
    sat_s    = 1'b0;
    if (!sum_s[DATA_W] && sum_s[DATA_W-1]) begin
      result_s = POS_MAX;
      sat_s    = 1'b1;
    end else if (sum_s[DATA_W] && !sum_s[DATA_W-1]) begin
      result_s = NEG_MIN;
      sat_s    = 1'b1;
    end else begin
      result_s = sum_s[DATA_W-1:0];
      sat_s    = 1'b0;
    end
  end

  // LFSR: seed load wins over advance; a zero seed would lock up, so fall back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_r <= LFSR_SEED;
    end else if (seed_load) begin
      lfsr_r <= (seed == '0) ? LFSR_SEED : seed;
    end else if (accept_s) begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  // Saturation event counter, sticks at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_count <= '0;
    end else if (accept_s && sat_s && (sat_count != SAT_MAX)) begin
      sat_count <= sat_count + {{(SAT_W-1){1'b0}}, 1'b1};
    end
  end

  // Two-entry buffer: out_data is the head, tail_r the second entry.
  // in_ready/out_valid are registered alongside the state so they never
  // depend combinationally on out_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= EMPTY;
      out_data  <= '0;
      tail_r    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            out_data  <= result_s;
            out_valid <= 1'b1;
            state_r   <= ONE;
          end
        end
        ONE: begin
          if (accept_s && !pop_s) begin
            tail_r   <= result_s;
            in_ready <= 1'b0;
            state_r  <= FULL;
          end else if (pop_s && !accept_s) begin
            out_valid <= 1'b0;
            state_r   <= EMPTY;
          end else if (accept_s && pop_s) begin
            out_data <= result_s;
          end
        end
        FULL: begin
          if (pop_s) begin
            out_data <= tail_r;
            in_ready <= 1'b1;
            state_r  <= ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_r   <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noise_injector.sv
// Directed bench for noise_injector with a reference model and scoreboard.
module tb_noise_injector;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        noise_en;
  logic [4:0]  noise_shift;
  logic        seed_load;
  logic [23:0] seed;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic [15:0] sat_count;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          pops     = 0;
  int          pops0;
  logic [23:0] exp_q[$];
  logic [23:0] m_lfsr;
  int          m_sat;

  always #5 clk = ~clk;

  noise_injector dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .noise_en    (noise_en),
    .noise_shift (noise_shift),
    .seed_load   (seed_load),
    .seed        (seed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .sat_count   (sat_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] adv(input logic [23:0] l);
    return l[0] ? ((l >> 1) ^ 24'hE10000) : (l >> 1);
  endfunction

  function automatic logic [23:0] model(input logic [23:0] d, input logic [23:0] l,
                                        input logic en, input logic [4:0] sh,
                                        output logic sat);
    longint n;
    longint s;
    n = 0;
    if (en && (sh < 5'd24)) n = longint'($signed(l)) >>> sh;
    s = longint'($signed(d)) + n;
    sat = 1'b0;
    if (s > 64'sd8388607) begin
      s = 64'sd8388607;
      sat = 1'b1;
    end else if (s < -64'sd8388608) begin
      s = -64'sd8388608;
      sat = 1'b1;
    end
    return s[23:0];
  endfunction

  // One clock: score the handshakes that will fire at the coming edge.
  task automatic step();
    logic        acc;
    logic        pp;
    logic        s;
    logic [23:0] e;
    acc = in_valid && in_ready;
    pp  = out_valid && out_ready;
    if (pp) begin
      pops++;
      check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
    if (acc) begin
      e = model(in_data, m_lfsr, noise_en, noise_shift, s);
      exp_q.push_back(e);
      if (s && m_sat < 65535) m_sat++;
    end
    if (seed_load) m_lfsr = (seed == 24'd0) ? 24'hACE15B : seed;
    else if (acc) m_lfsr = adv(m_lfsr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = 24'd0; noise_en = 1'b0;
    noise_shift = 5'd0; seed_load = 1'b0; seed = 24'd0; out_ready = 1'b0;
    m_lfsr = 24'hACE15B; m_sat = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sat", 32'(sat_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Pass-through
    out_ready = 1'b1; in_valid = 1'b1; in_data = 24'h000123;
    step();
    in_valid = 1'b0;
    check("pt_valid", 32'(out_valid), 32'd1);
    check("pt_data", 32'(out_data), 32'h000123);
    step();
    check("pt_sat", 32'(sat_count), 32'd0);

    // Seeded shift
    seed_load = 1'b1; seed = 24'h000100;
    step();
    seed_load = 1'b0; noise_en = 1'b1; noise_shift = 5'd4;
    in_valid = 1'b1; in_data = 24'h000005;
    step();
    check("seed_out0", 32'(out_data), 32'h000015);
    in_data = 24'h000000;
    step();
    check("seed_out1", 32'(out_data), 32'h000008);
    in_valid = 1'b0;
    step();

    // Positive then negative saturation
    seed_load = 1'b1; seed = 24'h7FFFFF;
    step();
    seed_load = 1'b0; noise_shift = 5'd0; in_valid = 1'b1; in_data = 24'h7FFFF0;
    step();
    in_valid = 1'b0;
    check("psat_data", 32'(out_data), 32'h7FFFFF);
    check("psat_cnt", 32'(sat_count), 32'd1);
    step();
    seed_load = 1'b1; seed = 24'h800000;
    step();
    seed_load = 1'b0; in_valid = 1'b1; in_data = 24'h800010;
    step();
    in_valid = 1'b0;
    check("nsat_data", 32'(out_data), 32'h800000);
    check("nsat_cnt", 32'(sat_count), 32'd2);
    check("sat_model", 32'(sat_count), 32'(m_sat));
    step();

    // Backpressure
    noise_en = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 24'h111111;
    step();
    in_data = 24'h222222;
    step();
    check("bp_full_ready", 32'(in_ready), 32'd0);
    in_data = 24'h333333;
    step();
    check("bp_held_ready", 32'(in_ready), 32'd0);
    check("bp_head", 32'(out_data), 32'h111111);
    check("bp_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    check("bp_second", 32'(out_data), 32'h222222);
    step();
    in_valid = 1'b0;
    check("bp_third", 32'(out_data), 32'h333333);
    step();
    check("bp_drained", 32'(out_valid), 32'd0);
    check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Throughput with simultaneous accept and pop
    noise_en = 1'b1; noise_shift = 5'd8; pops0 = pops;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 24'($urandom);
      if (i == 3) noise_shift = 5'd30;
      step();
      if (i > 0) begin
        check("tp_in_ready", 32'(in_ready), 32'd1);
        check("tp_out_valid", 32'(out_valid), 32'd1);
      end
    end
    in_valid = 1'b0;
    step();
    check("tp_pops", 32'(pops - pops0), 32'd10);
    check("tp_drained", 32'(out_valid), 32'd0);

    // Mid-stream reset with a full buffer
    noise_en = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 24'h0000AA;
    step();
    step();
    in_valid = 1'b0;
    check("mr_full", 32'(in_ready), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_in_ready", 32'(in_ready), 32'd1);
    check("mr_sat", 32'(sat_count), 32'd0);
    exp_q.delete();
    m_lfsr = 24'hACE15B; m_sat = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Advance LFSR once, then zero-seed load must fall back to default seed
    out_ready = 1'b1; in_valid = 1'b1; in_data = 24'h000001;
    step();
    in_valid = 1'b0; seed_load = 1'b1; seed = 24'h000000;
    step();
    seed_load = 1'b0; noise_en = 1'b1; noise_shift = 5'd0;
    in_valid = 1'b1; in_data = 24'h000000;
    step();
    in_valid = 1'b0;
    check("zero_seed", 32'(out_data), 32'hACE15B);
    step();
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
